// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline stage.
package if_id_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } ifid_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;
    localparam int unsigned CNT_W     = 2;

    typedef logic [CNT_W-1:0] bubble_cnt_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_if.sv
// Fetch-side bus between the PC/IMEM, hazard unit and the IF/ID stage.
// IFID_PERF_EN adds the FetchCount/StallCount/FlushCount counters.
interface if_id_if;

    logic [31:0] PCResult;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Flush;
    logic [31:0] PCPlus4;
    logic        PCWrite;
    logic [31:0] IFID_PCPlus4;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
`ifdef IFID_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;

    modport master (
        output PCResult, Instruction, Stall, Flush,
        input  PCPlus4, PCWrite, IFID_PCPlus4, IFID_Instruction, IFID_Valid,
        input  FetchCount, StallCount, FlushCount
    );

    modport slave (
        input  PCResult, Instruction, Stall, Flush,
        output PCPlus4, PCWrite, IFID_PCPlus4, IFID_Instruction, IFID_Valid,
        output FetchCount, StallCount, FlushCount
    );
`else
    modport master (
        output PCResult, Instruction, Stall, Flush,
        input  PCPlus4, PCWrite, IFID_PCPlus4, IFID_Instruction, IFID_Valid
    );

    modport slave (
        input  PCResult, Instruction, Stall, Flush,
        output PCPlus4, PCWrite, IFID_PCPlus4, IFID_Instruction, IFID_Valid
    );
`endif

endinterface

// File: rtl/pc_increment.sv
// Combinational PC+4 adder; wraps modulo 2^32.
module pc_increment
    import if_id_pkg::*;
(
    input  logic [31:0] PCResult,
    output logic [31:0] PCPlus4
);

    assign PCPlus4 = PCResult + PC_INCR;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall/flush handling and post-flush NOP bubbles.
// IFID_PERF_EN enables saturating fetch/stall/flush counters.
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic   Clk,
    input  logic   Reset,
    if_id_if.slave bus
);

    localparam bubble_cnt_t RELOAD = bubble_cnt_t'(FLUSH_BUBBLES - 1);

    ifid_state_e state, state_next;
    bubble_cnt_t cnt, cnt_next;

    logic [31:0] pc_plus4;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        pc_write;
    logic        capture;
    logic        bubble;
    logic        stall_hold;

    pc_increment u_pc_increment (
        .PCResult (bus.PCResult),
        .PCPlus4  (pc_plus4)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_write   = 1'b1;
        capture    = 1'b0;
        bubble     = 1'b0;
        stall_hold = 1'b0;
        unique case (state)
            RUN, HOLD: begin
                if (bus.Flush) begin
                    bubble = 1'b1;
                    if (FLUSH_BUBBLES > 1) begin
                        state_next = SQUASH;
                        cnt_next   = RELOAD;
                    end else begin
                        state_next = RUN;
                    end
                end else if (bus.Stall) begin
                    pc_write   = 1'b0;
                    stall_hold = 1'b1;
                    state_next = HOLD;
                end else begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            SQUASH: begin
                bubble = 1'b1;
                // Stall is ignored here; a Flush restarts the bubble window.
                if (bus.Flush) begin
                    cnt_next = RELOAD;
                end else begin
                    pc_write = 1'b0;
                    cnt_next = bubble_cnt_t'(cnt - 1'b1);
                    if (cnt <= bubble_cnt_t'(1)) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= RUN;
            cnt        <= '0;
            ifid_pc4   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (bubble) begin
                ifid_pc4   <= '0;
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else if (capture) begin
                ifid_pc4   <= pc_plus4;
                ifid_instr <= bus.Instruction;
                ifid_valid <= 1'b1;
            end
        end
    end

    assign bus.PCPlus4          = pc_plus4;
    assign bus.PCWrite          = pc_write | ~Reset;
    assign bus.IFID_PCPlus4     = ifid_pc4;
    assign bus.IFID_Instruction = ifid_instr;
    assign bus.IFID_Valid       = ifid_valid;

`ifdef IFID_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (capture)    fetch_cnt <= sat_inc(fetch_cnt);
            if (stall_hold) stall_cnt <= sat_inc(stall_cnt);
            if (bus.Flush)  flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign bus.FetchCount = fetch_cnt;
    assign bus.StallCount = stall_cnt;
    assign bus.FlushCount = flush_cnt;
`endif

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side pipeline stage sitting directly downstream of the program counter register in the MIPS datapath. Each cycle it computes PC+4 from the current PC and registers it, together with the instruction read from instruction memory, into the IF/ID pipeline register. It applies hazard-unit stall and flush requests and drives the PC write-enable back upstream. After a flush it inserts a configurable number of NOP bubbles.

## Interface
Parameters:
- FLUSH_BUBBLES, 1: total NOP cycles presented to ID per flush, legal range 1..3.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  reset; synchronous, active-low (Reset==0 at posedge resets).
- PCResult  input  32  current PC from the program counter register.
- Instruction  input  32  instruction-memory read data at PCResult (combinational read).
- Stall  input  1  hazard unit hold request.
- Flush  input  1  branch/jump taken; squash the fetched instruction.
- PCPlus4  output  32  combinational PCResult+4, fed to the next-PC mux.
- PCWrite  output  1  combinational PC write enable.
- IFID_PCPlus4  output  32  registered PC+4.
- IFID_Instruction  output  32  registered instruction; 32'h0 (sll $0,$0,0) when bubbled.
- IFID_Valid  output  1  registered; 1 when IFID_Instruction is a real fetch.

## Operation
- Arithmetic: PCPlus4 = PCResult + 4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000. No overflow flag.
- States:
  - RUN: reset state.
  - HOLD: stalled.
  - SQUASH: post-flush bubbles; only reachable when FLUSH_BUBBLES>1.
- Priority: Reset > Flush > Stall > normal capture.
- RUN or HOLD, Flush=1:
  - IFID_Instruction=0, IFID_Valid=0, IFID_PCPlus4=0.
  - PCWrite=1, so the PC loads the redirect target.
  - If FLUSH_BUBBLES>1: bubble counter loads FLUSH_BUBBLES-1 and the next state is SQUASH. Otherwise the next state is RUN.
- RUN or HOLD, Stall=1, Flush=0: all IF/ID registers hold, PCWrite=0, next state HOLD.
- RUN or HOLD, neither asserted:
  - IFID_* capture {PCPlus4, Instruction, 1}.
  - PCWrite=1, next state RUN.
- SQUASH:
  - IF/ID outputs hold the NOP/Valid=0 pattern. PCWrite=0, so the PC holds the redirect target.
  - Counter decrements every cycle regardless of Stall. When it reaches 0, the next state is RUN.
  - Flush in SQUASH reloads the counter to FLUSH_BUBBLES-1 and sets PCWrite=1 for that cycle.
- Stall during the final SQUASH cycle is honoured on the following cycle, in RUN.
- Reset (any state, mid-stall or mid-squash):
  - IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0.
  - State=RUN, counter=0.
  - PCWrite=1 while Reset==0; the PC's own reset dominates.

## Timing
- Capture latency: 1 cycle, from PC/Instruction at edge N to IFID_* after edge N.
- PCWrite and PCPlus4: zero-latency combinational, from Stall, Flush, state and PCResult. No combinational path to IFID_*.
- Flush costs exactly FLUSH_BUBBLES ID-stage bubbles.
- Stall of k cycles holds IF/ID for k cycles; the held instruction is never lost or duplicated.
- Reset release: the first edge with Reset==1 captures the instruction at PC 0x00000000.

## Configuration
- IFID_PERF_EN defined: adds three 32-bit saturating output counters, all reset to 0 (saturate at 0xFFFFFFFF):
  - FetchCount: increments on Valid captures.
  - StallCount: increments on cycles with PCWrite=0 due to Stall.
  - FlushCount: increments on Flush edges.
- IFID_PERF_EN undefined: the counters and their ports are absent. Functional behaviour is identical.

## Structure
- Package if_id_pkg holds:
  - the state enum (RUN, HOLD, SQUASH);
  - NOP_INSTR = 32'h00000000;
  - PC_INCR = 4;
  - counter width = 2.
- One sub-module, pc_increment: the combinational 32-bit +4 adder. Everything else lives in if_id_stage.

## Test plan
- Reset then run:
  - Stimulus: Reset low 2 cycles, then PCResult 0,4,8 with Instruction 0x20080005, 0x20090003, 0x01095020.
  - Response: IFID_PCPlus4 = 4,8,12, the instructions in order, Valid=1, PCWrite=1.
- Stall:
  - Stimulus: Stall high 3 cycles while PCResult=0x10 holds Instruction 0x8C080000.
  - Response: IFID_* frozen on the prior capture, PCWrite=0 for 3 cycles, then 0x8C080000 / PCPlus4=0x14 captured once.
- Flush with FLUSH_BUBBLES=1, and Flush plus Stall together:
  - Stimulus: Flush at PCResult=0x20.
  - Response: next IFID_Instruction=0, Valid=0, PCWrite=1; next-cycle capture Valid=1.
  - Stimulus: Flush and Stall asserted together.
  - Response: same; Flush wins.
- FLUSH_BUBBLES=3:
  - Stimulus: Flush.
  - Response: 3 consecutive Valid=0 outputs, PCWrite high on cycle 1 then low on cycles 2-3.
  - Stimulus: second Flush during the 2nd bubble.
  - Response: the 3-bubble window restarts.
- Wrap and mid-operation reset:
  - Stimulus: PCResult=0xFFFFFFFC.
  - Response: PCPlus4=0, IFID_PCPlus4=0.
  - Stimulus: Reset low during HOLD.
  - Response: all outputs zero, Valid=0, state RUN, next capture normal.
- IFID_PERF_EN:
  - Stimulus: 5 fetches, 2 stall cycles, 1 flush.
  - Response: FetchCount=5, StallCount=2, FlushCount=1.
